// File: rtl/newton_operand_gen.sv
// Front end of the fast inverse square root pipeline: forms y0 = magic - (x >> 1)
// and NumB = (x/2) * y0 * y0 through a three-register truncating FP multiply chain.
module newton_operand_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] NumIn,
    output logic        out_valid,
    output logic [31:0] NumB,
    output logic [31:0] Init,
    output logic        err
);

    localparam logic [31:0] MAGIC = 32'h5F3759DF;

    // Sign-free truncating multiply; zero exponent means zero, underflow flushes,
    // overflow saturates to +inf.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        logic [9:0]  e;
        logic [31:0] r;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        m = p[47] ? p[46:24] : p[45:23];
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127 + {9'd0, p[47]};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            r = 32'h0000_0000;
        end else if ($signed(e) <= 10'sd0) begin
            r = 32'h0000_0000;
        end else if ($signed(e) >= 10'sd255) begin
            r = 32'h7F80_0000;
        end else begin
            r = {1'b0, e[7:0], m};
        end
        return r;
    endfunction

    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] init_s1_q, init_s1_d;
    logic [31:0] halfx_s1_q, halfx_s1_d;
    logic        err_s1_q, err_s1_d;
    logic [31:0] y2_s2_q, y2_s2_d;
    logic [31:0] halfx_s2_q, halfx_s2_d;
    logic [31:0] init_s2_q, init_s2_d;
    logic        err_s2_q, err_s2_d;
    logic [31:0] numb_q, numb_d;
    logic [31:0] init_q, init_d;
    logic        err_q, err_d;

    always_comb begin
        v1_d        = in_valid;
        v2_d        = v1_q;
        out_valid_d = v2_q;

        init_s1_d  = init_s1_q;
        halfx_s1_d = halfx_s1_q;
        err_s1_d   = err_s1_q;
        y2_s2_d    = y2_s2_q;
        halfx_s2_d = halfx_s2_q;
        init_s2_d  = init_s2_q;
        err_s2_d   = err_s2_q;
        numb_d     = numb_q;
        init_d     = init_q;
        err_d      = err_q;

        if (in_valid) begin
            init_s1_d = MAGIC - {1'b0, NumIn[31:1]};
            // Halving a value with exponent 0 or 1 leaves the normal range.
            if (NumIn[30:23] <= 8'd1) begin
                halfx_s1_d = 32'h0000_0000;
            end else begin
                halfx_s1_d = {1'b0, NumIn[30:23] - 8'd1, NumIn[22:0]};
            end
            err_s1_d = NumIn[31] | (NumIn[30:23] == 8'd0);
        end

        if (v1_q) begin
            y2_s2_d    = fmul(init_s1_q, init_s1_q);
            halfx_s2_d = halfx_s1_q;
            init_s2_d  = init_s1_q;
            err_s2_d   = err_s1_q;
        end

        if (v2_q) begin
            numb_d = err_s2_q ? 32'h0000_0000 : fmul(halfx_s2_q, y2_s2_q);
            init_d = init_s2_q;
            err_d  = err_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            init_s1_q   <= 32'd0;
            halfx_s1_q  <= 32'd0;
            err_s1_q    <= 1'b0;
            y2_s2_q     <= 32'd0;
            halfx_s2_q  <= 32'd0;
            init_s2_q   <= 32'd0;
            err_s2_q    <= 1'b0;
            numb_q      <= 32'd0;
            init_q      <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            init_s1_q   <= init_s1_d;
            halfx_s1_q  <= halfx_s1_d;
            err_s1_q    <= err_s1_d;
            y2_s2_q     <= y2_s2_d;
            halfx_s2_q  <= halfx_s2_d;
            init_s2_q   <= init_s2_d;
            err_s2_q    <= err_s2_d;
            numb_q      <= numb_d;
            init_q      <= init_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign NumB      = numb_q;
    assign Init      = init_q;
    assign err       = err_q;

endmodule

// File: tb/tb_newton_operand_gen.sv
// Directed and short random-stream bench for newton_operand_gen against a
// bit-accurate integer reference of the truncating multiply chain.
module tb_newton_operand_gen;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] NumIn;
    logic        out_valid;
    logic [31:0] NumB;
    logic [31:0] Init;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    newton_operand_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .NumIn     (NumIn),
        .out_valid (out_valid),
        .NumB      (NumB),
        .Init      (Init),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] init;
        logic [31:0] numb;
        logic        err;
        bit          use_model;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] ref_fmul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, prod, mant;
        int e;
        if (a[30:23] == 0 || b[30:23] == 0) return 32'h0;
        ma   = 64'h80_0000 | longint'(a[22:0]);
        mb   = 64'h80_0000 | longint'(b[22:0]);
        prod = ma * mb;
        e    = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod >= (64'd1 << 47)) begin
            mant = (prod >> 24) & 64'h7F_FFFF;
            e    = e + 1;
        end else begin
            mant = (prod >> 23) & 64'h7F_FFFF;
        end
        if (e <= 0) return 32'h0;
        if (e >= 255) return 32'h7F80_0000;
        return (32'(e) << 23) | 32'(mant);
    endfunction

    function automatic logic [31:0] ref_init(input logic [31:0] x);
        return 32'h5F37_59DF - (x >> 1);
    endfunction

    function automatic logic ref_err(input logic [31:0] x);
        return x[31] || (x[30:23] == 0);
    endfunction

    function automatic logic [31:0] ref_numb(input logic [31:0] x);
        logic [31:0] halfx, y0;
        if (ref_err(x)) return 32'h0;
        halfx = (x[30:23] <= 1) ? 32'h0 : (x - 32'h0080_0000);
        y0    = ref_init(x);
        return ref_fmul(halfx, ref_fmul(y0, y0));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs(input string name, input logic [31:0] x);
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " NumB"}, NumB, ref_numb(x));
        chk({name, " Init"}, Init, ref_init(x));
        chk({name, " err"}, 32'(err), 32'(ref_err(x)));
    endtask

    logic        iv_pat[27];
    logic [31:0] x_pat[27];
    logic [31:0] last_numb, last_init;

    initial begin
        vecs[0] = '{32'h406E_B3BE, 32'h3F00_0000, 32'h3EEE_B3BE, 1'b0, 1'b0};
        vecs[1] = '{32'h3F80_0000, 32'h3F77_59DF, 32'h0000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'hC080_0000, 32'hFEF7_59DF, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0000, 32'h5F37_59DF, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{32'h0080_0000, 32'h5EF7_59DF, 32'h0000_0000, 1'b0, 1'b0};

        rst      = 1'b0;
        in_valid = 1'b0;
        NumIn    = 32'h0;
        tick();
        tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset NumB", NumB, 32'd0);
        chk("reset Init", Init, 32'd0);
        chk("reset err", 32'(err), 32'd0);
        rst = 1'b1;
        tick();

        // Single pulses with latency check.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            NumIn    = vecs[i].x;
            tick();
            in_valid = 1'b0;
            NumIn    = 32'hDEAD_BEEF;
            chk($sformatf("vec%0d early1", i), 32'(out_valid), 32'd0);
            tick();
            chk($sformatf("vec%0d early2", i), 32'(out_valid), 32'd0);
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d Init", i), Init, vecs[i].init);
            chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].err));
            if (vecs[i].use_model) begin
                chk($sformatf("vec%0d NumB", i), NumB, ref_numb(vecs[i].x));
                chk($sformatf("vec%0d NumB exp", i), 32'(NumB[30:23]), 32'h7D);
                chk($sformatf("vec%0d NumB sign", i), 32'(NumB[31]), 32'd0);
            end else begin
                chk($sformatf("vec%0d NumB", i), NumB, vecs[i].numb);
            end
            tick();
            chk($sformatf("vec%0d drop", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d hold Init", i), Init, vecs[i].init);
        end

        // 16 back-to-back, 3 idle, 4 more, then drain.
        for (int k = 0; k < 27; k++) begin
            iv_pat[k] = (k < 16) || (k >= 19 && k < 23);
            x_pat[k]  = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        last_numb = NumB;
        last_init = Init;
        for (int k = 0; k < 27; k++) begin
            in_valid = iv_pat[k];
            NumIn    = x_pat[k];
            tick();
            if (k >= 2 && iv_pat[k-2]) begin
                chk_outputs($sformatf("stream%0d", k - 2), x_pat[k-2]);
                last_numb = NumB;
                last_init = Init;
            end else begin
                chk($sformatf("stream gap valid @%0d", k), 32'(out_valid), 32'd0);
                chk($sformatf("stream gap NumB hold @%0d", k), NumB, last_numb);
                chk($sformatf("stream gap Init hold @%0d", k), Init, last_init);
            end
        end
        in_valid = 1'b0;
        tick();

        // Reset with two samples in flight and a sample offered during reset.
        in_valid = 1'b1;
        NumIn    = 32'h406E_B3BE;
        tick();
        NumIn    = 32'h3F80_0000;
        tick();
        rst      = 1'b0;
        NumIn    = 32'h4080_0000;
        tick();
        chk("rst flush out_valid", 32'(out_valid), 32'd0);
        chk("rst flush NumB", NumB, 32'd0);
        chk("rst flush Init", Init, 32'd0);
        chk("rst flush err", 32'(err), 32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk($sformatf("post-rst idle%0d", j), 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        NumIn    = 32'h4100_0000;
        tick();
        in_valid = 1'b0;
        chk("post-rst early1", 32'(out_valid), 32'd0);
        tick();
        chk("post-rst early2", 32'(out_valid), 32'd0);
        tick();
        chk_outputs("post-rst sample", 32'h4100_0000);
        tick();
        chk("post-rst single", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
